// File: rtl/hazard_scoreboard.sv
// In-flight writeback scoreboard: tracks DEPTH stages after issue and produces
// load-use stall, flush kill and per-operand forwarding decisions.

module hazard_stage_cmp #(
   parameter int REG_AW     = 5,
   parameter int LOAD_STAGE = 2,
   parameter int ZERO_REG   = 1,
   parameter int STAGE      = 0
) (
   input  logic              i_v,
   input  logic              i_we,
   input  logic              i_ld,
   input  logic [REG_AW-1:0] i_dst,
   input  logic [REG_AW-1:0] i_srca,
   input  logic [REG_AW-1:0] i_srcb,
   input  logic              i_chk_a,
   input  logic              i_chk_b,
   output logic              o_match_a,
   output logic              o_match_b,
   output logic              o_ready
);
   logic w_live;
   logic w_zero_a;
   logic w_zero_b;

   assign w_live    = i_v & i_we;
   assign w_zero_a  = (ZERO_REG != 0) && (i_srca == '0);
   assign w_zero_b  = (ZERO_REG != 0) && (i_srcb == '0);
   assign o_match_a = i_chk_a & w_live & (i_dst == i_srca) & ~w_zero_a;
   assign o_match_b = i_chk_b & w_live & (i_dst == i_srcb) & ~w_zero_b;
   // Load data only exists from LOAD_STAGE onwards; ALU results are ready at once.
   assign o_ready   = ~i_ld | (STAGE >= LOAD_STAGE);
endmodule

module hazard_scoreboard #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int DEPTH       = 3,
   parameter int LOAD_STAGE  = 2,
   parameter int FLUSH_DEPTH = 2,
   parameter int ZERO_REG    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    issue_valid,
   input  logic                    issue_we,
   input  logic                    issue_load,
   input  logic [REG_AW-1:0]       issue_dst,
   input  logic [REG_AW-1:0]       issue_srca,
   input  logic [REG_AW-1:0]       issue_srcb,
   input  logic                    issue_useb,
   input  logic                    flush,
   input  logic [DEPTH*DATA_W-1:0] stage_data,
   output logic                    issue_ready,
   output logic                    stall,
   output logic                    fwd_a_hit,
   output logic                    fwd_b_hit,
   output logic [DATA_W-1:0]       fwd_a_data,
   output logic [DATA_W-1:0]       fwd_b_data,
   output logic                    wb_valid,
   output logic [REG_AW-1:0]       wb_dst,
   output logic [15:0]             stall_count
);
   logic [DEPTH-1:0]             r_vld;
   logic [DEPTH-1:0]             r_we;
   logic [DEPTH-1:0]             r_ld;
   logic [DEPTH-1:0][REG_AW-1:0] r_dst;
   logic [15:0]                  r_stall_cnt;

   logic [DEPTH-1:0]  w_match_a;
   logic [DEPTH-1:0]  w_match_b;
   logic [DEPTH-1:0]  w_rdy;
   logic              w_chk_a;
   logic              w_chk_b;
   logic              w_hit_a;
   logic              w_hit_b;
   logic              w_blk_a;
   logic              w_blk_b;
   logic [DATA_W-1:0] w_data_a;
   logic [DATA_W-1:0] w_data_b;
   logic              w_stall;
   logic              w_accept;

   assign w_chk_a = issue_valid;
   assign w_chk_b = issue_valid & issue_useb;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      hazard_stage_cmp #(
         .REG_AW    (REG_AW),
         .LOAD_STAGE(LOAD_STAGE),
         .ZERO_REG  (ZERO_REG),
         .STAGE     (g)
      ) u_cmp (
         .i_v      (r_vld[g]),
         .i_we     (r_we[g]),
         .i_ld     (r_ld[g]),
         .i_dst    (r_dst[g]),
         .i_srca   (issue_srca),
         .i_srcb   (issue_srcb),
         .i_chk_a  (w_chk_a),
         .i_chk_b  (w_chk_b),
         .o_match_a(w_match_a[g]),
         .o_match_b(w_match_b[g]),
         .o_ready  (w_rdy[g])
      );
   end

   // Scan oldest to youngest so the youngest match overwrites; a young
   // not-ready match therefore masks any older ready one.
   always_comb begin
      w_hit_a  = 1'b0;
      w_blk_a  = 1'b0;
      w_data_a = '0;
      w_hit_b  = 1'b0;
      w_blk_b  = 1'b0;
      w_data_b = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (w_match_a[k]) begin
            w_hit_a  = w_rdy[k];
            w_blk_a  = ~w_rdy[k];
            w_data_a = w_rdy[k] ? stage_data[k*DATA_W +: DATA_W] : '0;
         end
         if (w_match_b[k]) begin
            w_hit_b  = w_rdy[k];
            w_blk_b  = ~w_rdy[k];
            w_data_b = w_rdy[k] ? stage_data[k*DATA_W +: DATA_W] : '0;
         end
      end
   end

   assign w_stall  = (w_blk_a | w_blk_b) & ~flush;
   assign w_accept = issue_valid & ~w_stall & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld       <= '0;
         r_we        <= '0;
         r_ld        <= '0;
         r_dst       <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_vld[0] <= w_accept;
         r_we[0]  <= issue_we;
         r_ld[0]  <= issue_load;
         r_dst[0] <= issue_dst;
         // Stages always advance; flush only clears the valid bit of the young ones.
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1] & ~(flush & (k <= FLUSH_DEPTH));
            r_we[k]  <= r_we[k-1];
            r_ld[k]  <= r_ld[k-1];
            r_dst[k] <= r_dst[k-1];
         end
         if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall       = w_stall;
   assign issue_ready = ~w_stall;
   assign fwd_a_hit   = w_hit_a;
   assign fwd_b_hit   = w_hit_b;
   assign fwd_a_data  = w_data_a;
   assign fwd_b_data  = w_data_b;
   assign wb_valid    = r_vld[DEPTH-1] & r_we[DEPTH-1];
   assign wb_dst      = r_dst[DEPTH-1];
   assign stall_count = r_stall_cnt;
endmodule
